// File: rtl/rx_timer_pkg.sv
// ============================================================================
// Module      : rx_timer_pkg
// Description : Shared state encoding and default sizing for the receive timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_BITS_PER_BYTE = 8;
  localparam int DEF_MAX_RUN_BITS  = 7;

  localparam int BIT_CNT_W  = 4;
  localparam int BYTE_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/rx_flex_counter.sv
// ============================================================================
// Module      : rx_flex_counter
// Description : Up-counter with synchronous clear and programmable rollover.
//               o_rollover_flag marks the increment that wraps the count to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_count_enable,
  input  logic [WIDTH-1:0] i_rollover_val,
  output logic [WIDTH-1:0] o_count_out,
  output logic             o_rollover_flag
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == (i_rollover_val - 1'b1));

  // Clear dominates, so a coincident increment can never report a rollover.
  assign o_rollover_flag = i_count_enable && !i_clear && w_at_last;
  assign o_count_out     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_timer.sv
// ============================================================================
// Module      : rx_timer
// Description : Receive bit/byte timing generator: edge-locked mid-bit strobe,
//               bit/byte counting and transition-loss detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE,
  parameter int MAX_RUN_BITS  = DEF_MAX_RUN_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_timer,
  input  logic                  d_edge,
  input  logic                  pause,
  input  logic                  clear_byte,
  output logic                  shift_strobe,
  output logic                  byte_rcvd,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  err_no_edge
);

  localparam int c_PHASE_W = $clog2(CLKS_PER_BIT);
  localparam int c_RUN_W   = $clog2(MAX_RUN_BITS + 1);

  localparam logic [c_PHASE_W-1:0] c_PHASE_ONE  = c_PHASE_W'(1);
  localparam logic [c_PHASE_W-1:0] c_PHASE_MID  = c_PHASE_W'(CLKS_PER_BIT / 2);
  localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(CLKS_PER_BIT - 1);

  localparam logic [BIT_CNT_W-1:0] c_BITS_ROLL = BIT_CNT_W'(BITS_PER_BYTE);
  localparam logic [c_RUN_W-1:0]   c_RUN_ROLL  = c_RUN_W'(MAX_RUN_BITS);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_PHASE_W-1:0]    r_phase;
  logic [c_PHASE_W-1:0]    w_phase_nxt;
  logic [BYTE_CNT_W-1:0]   r_byte_cnt;
  logic                    r_byte_rcvd;
  logic                    r_err;

  logic                    w_in_run;
  logic                    w_start;
  logic                    w_wrap;
  logic                    w_strobe;
  logic                    w_timeout;
  logic                    w_bit_clr;
  logic                    w_bit_roll;
  logic                    w_run_clr;
  logic                    w_run_inc;
  logic [BIT_CNT_W-1:0]    w_bit_cnt;
  logic [c_RUN_W-1:0]      w_run_cnt_unused;

  assign w_in_run = (r_state == RUN);
  assign w_start  = (r_state == IDLE) && enable_timer && d_edge;
  assign w_wrap   = w_in_run && (r_phase == c_PHASE_LAST);

  // Bit counter: counts accepted strobes, realigned by clear_byte.
  assign w_bit_clr = !enable_timer || !w_in_run || clear_byte || w_timeout;

  rx_flex_counter #(
    .WIDTH (BIT_CNT_W)
  ) u_bit_counter (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_bit_clr),
    .i_count_enable  (w_strobe),
    .i_rollover_val  (c_BITS_ROLL),
    .o_count_out     (w_bit_cnt),
    .o_rollover_flag (w_bit_roll)
  );

  // Run counter: whole bit periods elapsed since the last transition.
  assign w_run_clr = !enable_timer || !w_in_run || d_edge;
  assign w_run_inc = w_wrap && !d_edge;

  rx_flex_counter #(
    .WIDTH (c_RUN_W)
  ) u_run_counter (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_run_clr),
    .i_count_enable  (w_run_inc),
    .i_rollover_val  (c_RUN_ROLL),
    .o_count_out     (w_run_cnt_unused),
    .o_rollover_flag (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_strobe    = 1'b0;
    case (r_state)
      IDLE: begin
        w_phase_nxt = '0;
        if (w_start) begin
          w_state_nxt = RUN;
          w_phase_nxt = c_PHASE_ONE;
        end
      end
      RUN: begin
        w_strobe = (r_phase == c_PHASE_MID) && !pause;
        if (w_timeout) begin
          w_state_nxt = HALT;
          w_phase_nxt = '0;
        end else if (d_edge) begin
          w_phase_nxt = c_PHASE_ONE;
        end else if (r_phase == c_PHASE_LAST) begin
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + c_PHASE_ONE;
        end
      end
      HALT: begin
        w_phase_nxt = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    endcase
    if (!enable_timer) begin
      w_state_nxt = IDLE;
      w_phase_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // byte_cnt survives HALT so the failing packet can be inspected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_byte_rcvd <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_byte_rcvd <= w_bit_roll;
      r_err       <= w_timeout;
      if (!enable_timer || (r_state == IDLE)) begin
        r_byte_cnt <= '0;
      end else if (w_bit_roll && (r_byte_cnt != '1)) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
    end
  end

  assign shift_strobe = w_strobe;
  assign byte_rcvd    = r_byte_rcvd;
  assign bit_cnt      = w_bit_cnt;
  assign byte_cnt     = r_byte_cnt;
  assign err_no_edge  = r_err;

endmodule

`default_nettype wire

// File: doc/rx_timer.md
# rx_timer

Receive-side bit/byte timing generator for the USB-to-Ethernet bridge's serial receiver. Locks onto data-line transitions, produces one mid-bit sample strobe per bit period, counts bits into bytes and flags completed bytes to the receive shift register and packet FSM. Resynchronises its phase on every transition and flags loss of transitions as a receive error.

## Interface

- CLKS_PER_BIT, default 8: clocks per bit period; even, ≥4.
- BITS_PER_BYTE, default 8: bits per byte; ≤15.
- MAX_RUN_BITS, default 7: bit periods allowed without a transition before error.

Ports (one clock; reset is asynchronous and active-high):

- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable_timer  in  1  level; high while packet reception is active.
- d_edge  in  1  one-cycle pulse, already synchronised, marking a data-line transition.
- pause  in  1  level; high marks the current bit as a stuffed bit to be discarded.
- clear_byte  in  1  synchronous byte-boundary realign; clears bit_cnt.
- shift_strobe  out  1  one-cycle mid-bit sample enable.
- byte_rcvd  out  1  registered one-cycle pulse after the last bit of a byte.
- bit_cnt  out  4  bits accepted in the current byte.
- byte_cnt  out  8  bytes completed this packet; saturates at 255.
- err_no_edge  out  1  registered one-cycle pulse on transition timeout.

## Operation

- States: IDLE, RUN, HALT.
- IDLE: phase, bit_cnt, byte_cnt and run counter held at 0. Transition to RUN when enable_timer=1 and d_edge=1 in the same cycle.
- Phase counter, width $clog2(CLKS_PER_BIT), range 0..CLKS_PER_BIT-1. The edge cycle is phase 0.
  - On d_edge in RUN or on IDLE→RUN, next phase = 1.
  - Otherwise next phase = phase+1, wrapping CLKS_PER_BIT-1→0.
- shift_strobe = (state==RUN) && (phase==CLKS_PER_BIT/2) && !pause. It is a combinational decode of registers plus pause.
- Bit counting: each strobe increments bit_cnt.
  - On the strobe that makes the count BITS_PER_BYTE, bit_cnt returns to 0, byte_rcvd pulses the next cycle, and byte_cnt increments with saturation.
- pause during the strobe phase: no strobe, no count, phase advances normally.
- Run counter: increments at each phase wrap with no d_edge and clears on d_edge.
  - Reaching MAX_RUN_BITS triggers the error path: err_no_edge pulses next cycle, state goes to HALT, and phase and bit_cnt clear. byte_cnt is held for diagnosis.
- HALT: no strobes; stays in HALT until enable_timer=0.
- enable_timer=0 in any state: IDLE next cycle, all counters clear, no byte_rcvd or err pulse generated from that cycle.
- clear_byte has priority over counting. If a strobe coincides with clear_byte, bit_cnt=0 and no byte_rcvd.
- d_edge coinciding with phase==CLKS_PER_BIT/2: the strobe still fires this cycle and the next phase is 1.

## Timing

- Reset values: state IDLE, phase 0, bit_cnt 0, byte_cnt 0, shift_strobe 0, byte_rcvd 0, err_no_edge 0.
- Strobe latency: first strobe CLKS_PER_BIT/2 cycles after the edge cycle. With the default of 8, edge at cycle t gives a strobe at cycle t+4, then every 8 cycles absent edges.
- byte_rcvd: exactly 1 cycle after the final shift_strobe of a byte.
- err_no_edge: 1 cycle after the phase wrap that reaches MAX_RUN_BITS.
- Reset asserted mid-packet: all outputs 0 immediately (asynchronous). After release, the block waits in IDLE for the next enable_timer && d_edge.

## Structure

- Package rx_timer_pkg: state enum (IDLE, RUN, HALT) and default parameter constants.
- Sub-module rx_flex_counter: parameterised width with clear, count_enable, rollover_val, rollover_flag and count_out, using active-high async reset.
  - Instantiated once for bit_cnt and once for the run counter.
  - Phase counter and byte_cnt stay inline because phase needs a load-to-1 and byte_cnt saturates.

## Test plan

- Start-up and cadence: enable_timer=1, d_edge at cycle 10, no further edges for 40 cycles. Required: strobes at cycles 14, 22, 30, 38, 46.
- Byte completion: edges every 8 cycles, 8 strobes, 16 strobes total. Required: byte_rcvd at the cycle after the 8th and after the 16th strobe; byte_cnt=2; bit_cnt=0.
- Resync: edge at cycle 10, then a second edge at cycle 17. Required: strobe at 14, next strobe at 21 (not 22).
- Stuffing and realign:
  - pause=1 at the 3rd strobe phase: required strobe suppressed and bit_cnt stays 2.
  - clear_byte coincident with the 8th strobe: required bit_cnt=0 and no byte_rcvd.
- Timeout: single edge then 7 edge-free bit periods. Required: err_no_edge one pulse at 1 cycle after the 7th wrap, HALT with no strobes; IDLE after enable_timer=0.
- Reset and disable mid-packet:
  - rst pulse after 5 bits: required all outputs 0 immediately.
  - enable_timer dropped with a byte completing the same cycle: required no byte_rcvd.
